// File: rtl/bpm_window_ctrl.sv
// Gate-window controller for a BPM meter: clears and enables the pulse counter for one window, then latches count*MULT.
// The result is available one cycle after CAPTURE; bpm_valid is held until acknowledged, and newer captures overwrite it.
module bpm_window_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int WINDOW_S = 15,
  parameter int MULT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic [7:0]  cnt_bin,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic        busy,
  output logic [5:0]  sec_left,
  output logic [15:0] bpm,
  output logic        bpm_ovf,
  output logic        bpm_valid,
  input  logic        bpm_ack
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // sec_left steps one cycle before the tick wraps so it reads 0 on the final COUNT cycle
  localparam logic [TW-1:0] TICK_DEC  = TW'(TICK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          settle_cnt;
  logic          ovf_trk;
  logic          cnt_sat;
  logic          capture;

  assign cnt_sat = (cnt_bin == 8'hFF);
  assign capture = (state == S_CAPTURE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_CLEAR;
        S_CLEAR:   state_nxt = S_COUNT;
        S_COUNT:   if (tick_cnt == TICK_LAST && sec_left == 6'd0) state_nxt = S_SETTLE;
        S_SETTLE:  if (settle_cnt) state_nxt = S_CAPTURE;
        S_CAPTURE: state_nxt = cont ? S_CLEAR : S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy    = 1'b0;
    case (state)
      S_CLEAR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
      end
      S_COUNT: begin
        cnt_en = 1'b1;
        busy   = 1'b1;
      end
      S_SETTLE, S_CAPTURE: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      settle_cnt <= 1'b0;
      sec_left   <= 6'd0;
      ovf_trk    <= 1'b0;
    end else begin
      if (state != S_COUNT || tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      settle_cnt <= (state == S_SETTLE);

      if (abort && state != S_IDLE) begin
        sec_left <= 6'd0;
      end else if (state_nxt == S_CLEAR) begin
        sec_left <= 6'(WINDOW_S);
      end else if (state == S_COUNT && tick_cnt == TICK_DEC && sec_left != 6'd0) begin
        sec_left <= sec_left - 6'd1;
      end

      if (state_nxt == S_CLEAR) begin
        ovf_trk <= 1'b0;
      end else if (cnt_sat && (state == S_COUNT || state == S_SETTLE || state == S_CAPTURE)) begin
        ovf_trk <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpm       <= 16'd0;
      bpm_ovf   <= 1'b0;
      bpm_valid <= 1'b0;
    end else begin
      if (capture) begin
        bpm       <= 16'(cnt_bin) * 16'(MULT);
        bpm_ovf   <= ovf_trk | cnt_sat;
        bpm_valid <= 1'b1;
      end else if (bpm_ack && bpm_valid) begin
        bpm_valid <= 1'b0;
      end
    end
  end

endmodule
